// File: rtl/alu_rf_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rf_if
//  Description : Register-file and ALU signal bundle for the alu_rf core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_rf_if;
    logic        write;
    logic [1:0]  addr1;
    logic [1:0]  addr2;
    logic [1:0]  addr3;
    logic [15:0] data3;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic [15:0] C;
    logic        zero;

    modport master (
        output write, addr1, addr2, addr3, data3, A, B, opcode, func,
        input  data1, data2, C, zero
    );

    modport slave (
        input  write, addr1, addr2, addr3, data3, A, B, opcode, func,
        output data1, data2, C, zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_rf.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rf
//  Description : 4 x 16-bit register file plus combinational 16-bit ALU.
//                Define ALU_RF_BYPASS_EN for write-to-read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rf (
    input  wire logic clk,
    input  wire logic reset_n,
    alu_rf_if.slave   bus
);
    localparam logic [3:0] c_op_bne   = 4'd0;
    localparam logic [3:0] c_op_beq   = 4'd1;
    localparam logic [3:0] c_op_bgz   = 4'd2;
    localparam logic [3:0] c_op_blz   = 4'd3;
    localparam logic [3:0] c_op_ori   = 4'd5;
    localparam logic [3:0] c_op_lhi   = 4'd6;
    localparam logic [3:0] c_op_rtype = 4'd15;

    localparam logic [5:0] c_fn_add = 6'd0;
    localparam logic [5:0] c_fn_sub = 6'd1;
    localparam logic [5:0] c_fn_and = 6'd2;
    localparam logic [5:0] c_fn_orr = 6'd3;
    localparam logic [5:0] c_fn_not = 6'd4;
    localparam logic [5:0] c_fn_tcp = 6'd5;
    localparam logic [5:0] c_fn_shl = 6'd6;
    localparam logic [5:0] c_fn_shr = 6'd7;

    logic [15:0] r_regs [4];
    logic [15:0] w_c;
    logic        w_zero;

    // reset_n is active-high despite its name; reset wins over a pending write
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (bus.write) begin
            r_regs[bus.addr3] <= bus.data3;
        end
    end

`ifdef ALU_RF_BYPASS_EN
    logic w_wr_live;
    assign w_wr_live = bus.write && !reset_n;
    assign bus.data1 = (w_wr_live && (bus.addr1 == bus.addr3)) ? bus.data3 : r_regs[bus.addr1];
    assign bus.data2 = (w_wr_live && (bus.addr2 == bus.addr3)) ? bus.data3 : r_regs[bus.addr2];
`else
    assign bus.data1 = r_regs[bus.addr1];
    assign bus.data2 = r_regs[bus.addr2];
`endif

    always_comb begin
        w_c = bus.A + bus.B;
        case (bus.opcode)
            c_op_ori: w_c = bus.A | {8'h00, bus.B[7:0]};
            c_op_lhi: w_c = {bus.B[7:0], 8'h00};
            c_op_rtype: begin
                case (bus.func)
                    c_fn_add: w_c = bus.A + bus.B;
                    c_fn_sub: w_c = bus.A - bus.B;
                    c_fn_and: w_c = bus.A & bus.B;
                    c_fn_orr: w_c = bus.A | bus.B;
                    c_fn_not: w_c = ~bus.A;
                    c_fn_tcp: w_c = ~bus.A + 16'd1;
                    c_fn_shl: w_c = {bus.A[14:0], 1'b0};
                    c_fn_shr: w_c = {bus.A[15], bus.A[15:1]};
                    default:  w_c = bus.A;
                endcase
            end
            default: w_c = bus.A + bus.B;
        endcase
    end

    // Branch opcodes compare operands directly; everything else flags a zero result
    always_comb begin
        case (bus.opcode)
            c_op_bne: w_zero = (bus.A != bus.B);
            c_op_beq: w_zero = (bus.A == bus.B);
            c_op_bgz: w_zero = !bus.A[15] && (bus.A != 16'h0000);
            c_op_blz: w_zero = bus.A[15];
            default:  w_zero = (w_c == 16'h0000);
        endcase
    end

    assign bus.C    = w_c;
    assign bus.zero = w_zero;
endmodule
`default_nettype wire

// File: tb/tb_alu_rf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rf
//  Description : Self-checking bench for alu_rf with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rf;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    logic [15:0] model_rf [4];

    alu_rf_if bus ();

    alu_rf dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU computed with wide signed integer arithmetic, truncated to 16 bits
    function automatic void alu_ref(input logic [3:0] op, input logic [5:0] fn,
                                    input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] c, output logic z);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        c  = 16'(ai + bi);
        if (op == 4'd5)      c = a | (b % 256);
        else if (op == 4'd6) c = 16'((b % 256) * 256);
        else if (op == 4'd15) begin
            case (fn)
                6'd0:    c = 16'(ai + bi);
                6'd1:    c = 16'(ai - bi);
                6'd2:    c = a & b;
                6'd3:    c = a | b;
                6'd4:    c = 16'(-ai - 1);
                6'd5:    c = 16'(-ai);
                6'd6:    c = 16'(ai * 2);
                6'd7:    c = 16'((ai - (ai < 0 ? 1 : 0)) / 2);
                default: c = a;
            endcase
        end
        case (op)
            4'd0:    z = (ai != bi);
            4'd1:    z = (ai == bi);
            4'd2:    z = (ai > 0);
            4'd3:    z = (ai < 0);
            default: z = (c == 16'h0000);
        endcase
    endfunction

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [5:0] fn,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_c, input logic exp_z);
        bus.opcode = op;
        bus.func   = fn;
        bus.A      = a;
        bus.B      = b;
        #1;
        check({tag, "_C"}, bus.C, exp_c);
        check({tag, "_zero"}, {15'd0, bus.zero}, {15'd0, exp_z});
    endtask

    task automatic alu_rand_check();
        logic [15:0] mc;
        logic        mz;
        alu_ref(bus.opcode, bus.func, bus.A, bus.B, mc, mz);
        check("rand_C", bus.C, mc);
        check("rand_zero", {15'd0, bus.zero}, {15'd0, mz});
    endtask

    // One clock cycle of register-file traffic; reads are checked before the edge
    task automatic rf_cycle(input logic rst_i, input logic wr,
                            input logic [1:0] a1, input logic [1:0] a2,
                            input logic [1:0] a3, input logic [15:0] d3);
        logic [15:0] e1;
        logic [15:0] e2;
        reset_n   = rst_i;
        bus.write = wr;
        bus.addr1 = a1;
        bus.addr2 = a2;
        bus.addr3 = a3;
        bus.data3 = d3;
        #2;
        e1 = model_rf[a1];
        e2 = model_rf[a2];
`ifdef ALU_RF_BYPASS_EN
        if (wr && !rst_i && a1 == a3) e1 = d3;
        if (wr && !rst_i && a2 == a3) e2 = d3;
`endif
        check("rf_data1", bus.data1, e1);
        check("rf_data2", bus.data2, e2);
        @(posedge clk);
        if (rst_i) begin
            for (int i = 0; i < 4; i++) model_rf[i] = 16'h0000;
        end else if (wr) begin
            model_rf[a3] = d3;
        end
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b1;
        bus.write  = 1'b0;
        bus.addr1  = 2'd0;
        bus.addr2  = 2'd0;
        bus.addr3  = 2'd0;
        bus.data3  = 16'h0000;
        bus.A      = 16'h0000;
        bus.B      = 16'h0000;
        bus.opcode = 4'd0;
        bus.func   = 6'd0;
        for (int i = 0; i < 4; i++) model_rf[i] = 16'h0000;

        @(posedge clk);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.addr1 = 2'(i);
            #1;
            check("reset_state", bus.data1, 16'h0000);
        end

        // Reset clears r2 and drops the concurrent write to r1
        rf_cycle(1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 16'h1234);
        rf_cycle(1'b1, 1'b1, 2'd2, 2'd1, 2'd1, 16'h5555);
        rf_cycle(1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 16'h0000);
        bus.addr1 = 2'd2;
        bus.addr2 = 2'd1;
        #1;
        check("reset_r2", bus.data1, 16'h0000);
        check("reset_drop_wr", bus.data2, 16'h0000);

        rf_cycle(1'b0, 1'b1, 2'd1, 2'd3, 2'd1, 16'hABCD);
        rf_cycle(1'b0, 1'b1, 2'd1, 2'd3, 2'd3, 16'h0005);
        bus.write = 1'b0;
        #1;
        check("wr_r1", bus.data1, 16'hABCD);
        check("wr_r3", bus.data2, 16'h0005);

        alu_vec("add", 4'd15, 6'd0, 16'h8001, 16'h0003, 16'h8004, 1'b0);
        alu_vec("sub", 4'd15, 6'd1, 16'h8001, 16'h0003, 16'h7FFE, 1'b0);
        alu_vec("tcp", 4'd15, 6'd5, 16'h8001, 16'h0003, 16'h7FFF, 1'b0);
        alu_vec("shl", 4'd15, 6'd6, 16'h8001, 16'h0003, 16'h0002, 1'b0);
        alu_vec("shr", 4'd15, 6'd7, 16'h8001, 16'h0003, 16'hC000, 1'b0);
        alu_vec("not", 4'd15, 6'd4, 16'h8001, 16'h0003, 16'h7FFE, 1'b0);
        alu_vec("and", 4'd15, 6'd2, 16'h8001, 16'h0003, 16'h0001, 1'b0);
        alu_vec("orr", 4'd15, 6'd3, 16'h8001, 16'h0003, 16'h8003, 1'b0);
        alu_vec("jpr", 4'd15, 6'd25, 16'h8001, 16'h0003, 16'h8001, 1'b0);
        alu_vec("ori", 4'd5, 6'd0, 16'h00F0, 16'hFF0F, 16'h00FF, 1'b0);
        alu_vec("lhi", 4'd6, 6'd0, 16'h00F0, 16'hFF0F, 16'h0F00, 1'b0);
        alu_vec("adi", 4'd4, 6'd0, 16'h00F0, 16'hFF0F, 16'hFFFF, 1'b0);
        alu_vec("beq", 4'd1, 6'd0, 16'h0007, 16'h0007, 16'h000E, 1'b1);
        alu_vec("bne", 4'd0, 6'd0, 16'h0007, 16'h0007, 16'h000E, 1'b0);
        alu_vec("blz_neg", 4'd3, 6'd0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1);
        alu_vec("bgz_neg", 4'd2, 6'd0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
        alu_vec("bgz_zero", 4'd2, 6'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        alu_vec("blz_zero", 4'd3, 6'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        alu_vec("bgz_pos", 4'd2, 6'd0, 16'h0001, 16'h0000, 16'h0001, 1'b1);
        alu_vec("sub_zero", 4'd15, 6'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1);
        alu_vec("lwd_wrap", 4'd7, 6'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);

        for (int n = 0; n < 400; n++) begin
            bus.A      = 16'($urandom);
            bus.B      = ($urandom_range(0, 7) == 0) ? bus.A : 16'($urandom);
            bus.opcode = 4'($urandom_range(0, 15));
            bus.func   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(8, 63))
                                                      : 6'($urandom_range(0, 7));
            #1;
            alu_rand_check();
            rf_cycle(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom),
                     2'($urandom), 2'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
